sprite_evaluator: RTL and testbench
===================================

SPRITE_EVALUATOR -- requirements
Module: sprite_evaluator

Interface
REQ-001 SHALL have parameter MAX_SPRITES, default 8, meaning secondary-buffer capacity (power of two, 2..16).
REQ-002 SHALL have parameter OAM_ENTRIES, default 64, meaning number of 32-bit OAM entries scanned.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, meaning begin evaluation for the given scanline.
REQ-006 SHALL have port scanline, input, 8, meaning target scanline, sampled with start.
REQ-007 SHALL have port tall_sprites, input, 1, meaning sprite height 16 when 1, else 8, sampled with start.
REQ-008 SHALL have port oam_read_addr, output, 6, meaning the OAM read address; read data returns one cycle later.
REQ-009 SHALL have port oam_read_data, input, 32, meaning the OAM entry: [7:0] Y, [15:8] tile, [23:16] attributes, [31:24] X.
REQ-010 SHALL have port sec_write_addr, output, log2(MAX_SPRITES), meaning the secondary-buffer slot.
REQ-011 SHALL have port sec_write_data, output, 32, meaning the copied OAM entry.
REQ-012 SHALL have port sec_write_enable, output, 1, meaning a one-cycle write strobe.
REQ-013 SHALL have port busy, output, 1, meaning evaluation is in progress.
REQ-014 SHALL have port done, output, 1, meaning a one-cycle pulse when results are valid.
REQ-015 SHALL have port sprite_count, output, log2(MAX_SPRITES)+1, meaning in-range sprites stored, saturating at MAX_SPRITES.
REQ-016 SHALL have port overflow, output, 1, meaning more than MAX_SPRITES sprites are in range.
REQ-017 SHALL have port sprite0_hit, output, 1, meaning entry 0 is among the stored sprites.

Function
REQ-018 SHALL implement states IDLE, SCAN, DRAIN and DONE.
REQ-019 In IDLE, start=1 SHALL latch scanline and tall_sprites, clear sprite_count, overflow and sprite0_hit, reset the index to 0, and enter SCAN.
REQ-020 In SCAN, oam_read_addr SHALL equal the index, and the index SHALL increment by 1 each cycle; after address OAM_ENTRIES-1 is presented, the state SHALL become DRAIN.
REQ-021 Each entry SHALL be evaluated in the cycle after its address is presented; DRAIN covers the evaluation of the last entry, then the state SHALL become DONE.
REQ-022 In DONE, done SHALL be 1 for exactly one cycle, then the state SHALL become IDLE.
REQ-023 Latency: if start is sampled at edge 0, then address n SHALL be presented in cycle n+1, entry n SHALL be evaluated in cycle n+2, and done SHALL be asserted in cycle OAM_ENTRIES+2 (66 by default).
REQ-024 In-range test: compute d = {0,scanline} - {0,Y} in 9 bits; the entry is in range iff d[8]=0 and d[7:0] < height. There is no wrap-around, so Y > scanline is never in range.
REQ-025 For an in-range entry with sprite_count < MAX_SPRITES, the evaluation cycle SHALL assert sec_write_enable, set sec_write_addr = sprite_count and sec_write_data = oam_read_data, and increment sprite_count.
REQ-026 For an in-range entry with sprite_count = MAX_SPRITES, overflow SHALL be set, with no write and no count change.
REQ-027 sprite0_hit SHALL be set when entry 0 is written.
REQ-028 Slots SHALL be filled in ascending OAM index order, with no gaps.
REQ-029 busy SHALL be 1 in SCAN, DRAIN and DONE, and 0 in IDLE.
REQ-030 start SHALL be ignored while busy=1, with no restart and no effect on the current result.
REQ-031 sprite_count, overflow and sprite0_hit SHALL hold their values from done until the next accepted start.
REQ-032 oam_read_addr SHALL be 0 whenever the state is not SCAN.

Reset
REQ-033 reset=1 SHALL asynchronously force IDLE, index 0, and all outputs to 0: oam_read_addr, sec_write_addr, sec_write_data, sec_write_enable, busy, done, sprite_count, overflow and sprite0_hit.
REQ-034 Reset mid-SCAN SHALL abort with no further secondary writes, and no done pulse for the aborted run.
REQ-035 After reset is released, the first start SHALL be accepted on the next sampling edge.

Structure
REQ-036 The shared package ppu_pkg SHALL hold the state enum, the OAM entry field offsets (Y, tile, attributes, X) and OAM_ENTRIES.
REQ-037 The in-range test SHALL be a combinational sub-module sprite_range_check (inputs: scanline, Y, tall; output: hit).
REQ-038 The read-valid pipeline SHALL be a single registered flag plus the registered index, aligned with the one-cycle read latency.

Verification
REQ-039 Scenario: all Y=0xFF, scanline=100 -> no sec_write_enable pulses; done at cycle 66; count=0, overflow=0.
REQ-040 Scenario: entries 3, 10 and 40 have Y=96, others Y=0xFF, scanline=100, tall=0 -> writes to slots 0, 1 and 2 with data from entries 3, 10 and 40, in order; count=3.
REQ-041 Scenario: entries 0..9 have Y=50, scanline=57 -> slots 0..7 receive entries 0..7; count=8, overflow=1, sprite0_hit=1; scanline=58 instead -> count=0.
REQ-042 Scenario: tall=1, Y=50, scanline=65 -> hit; scanline=66 -> miss; Y=200, scanline=10 -> miss (no wrap).
REQ-043 Scenario: start pulsed again at cycle 30 of a run -> ignored; done still at cycle 66 with unchanged results.
REQ-044 Scenario: reset asserted at cycle 20 with 2 slots written -> immediate IDLE with all outputs 0; no done pulse; a fresh start completes normally.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared PPU definitions: evaluator state encoding, OAM entry layout and table size.
package ppu_pkg;

   localparam int OAM_ENTRIES = 64;

   localparam int OAM_Y_LSB    = 0;
   localparam int OAM_TILE_LSB = 8;
   localparam int OAM_ATTR_LSB = 16;
   localparam int OAM_X_LSB    = 24;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   function automatic logic [7:0] oam_y(input logic [31:0] entry);
      return entry[OAM_Y_LSB +: 8];
   endfunction

endpackage

// File: rtl/sprite_range_check.sv
// Combinational test: does a sprite whose top row is y cover the given scanline?
module sprite_range_check (
   input  logic [7:0] scanline,
   input  logic [7:0] y,
   input  logic       tall,
   output logic       hit
);

   logic [8:0] diff;

   // A borrow out of the 9-bit subtraction means the sprite starts below the line.
   assign diff = {1'b0, scanline} - {1'b0, y};
   assign hit  = ~diff[8] && (diff[7:0] < (tall ? 8'd16 : 8'd8));

endmodule

// File: rtl/sprite_evaluator.sv
// Scans OAM once per start, copying the first MAX_SPRITES entries that cover the
// latched scanline into the secondary buffer, in OAM order.
module sprite_evaluator #(
   parameter int MAX_SPRITES = 8,
   parameter int OAM_ENTRIES = ppu_pkg::OAM_ENTRIES
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   input  logic [7:0]                       scanline,
   input  logic                             tall_sprites,
   output logic [$clog2(OAM_ENTRIES)-1:0]   oam_read_addr,
   input  logic [31:0]                      oam_read_data,
   output logic [$clog2(MAX_SPRITES)-1:0]   sec_write_addr,
   output logic [31:0]                      sec_write_data,
   output logic                             sec_write_enable,
   output logic                             busy,
   output logic                             done,
   output logic [$clog2(MAX_SPRITES):0]     sprite_count,
   output logic                             overflow,
   output logic                             sprite0_hit
);

   import ppu_pkg::*;

   localparam int SLOT_W = $clog2(MAX_SPRITES);
   localparam int CNT_W  = SLOT_W + 1;
   localparam int IDX_W  = $clog2(OAM_ENTRIES);

   state_e            state;
   logic [IDX_W-1:0]  index;
   logic [IDX_W-1:0]  eval_index;
   logic              eval_valid;
   logic [7:0]        line_q;
   logic              tall_q;
   logic              in_range;
   logic              slot_free;
   logic              write_en;
   logic              overflow_hit;

   sprite_range_check u_range_check (
      .scanline (line_q),
      .y        (oam_y(oam_read_data)),
      .tall     (tall_q),
      .hit      (in_range)
   );

   assign slot_free    = (sprite_count < CNT_W'(MAX_SPRITES));
   assign write_en     = eval_valid && in_range && slot_free;
   assign overflow_hit = eval_valid && in_range && !slot_free;

   // NOTE: write-port outputs are gated by the strobe so they read zero whenever no
   // write happens, including throughout reset.
   assign sec_write_enable = write_en;
   assign sec_write_addr   = write_en ? sprite_count[SLOT_W-1:0] : '0;
   assign sec_write_data   = write_en ? oam_read_data : '0;

   assign oam_read_addr = (state == SCAN) ? index : '0;
   assign busy          = (state != IDLE);
   assign done          = (state == DONE);

   // NOTE: all state updates use non-blocking assignments so every register samples
   // the pre-edge values, regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         index        <= '0;
         eval_index   <= '0;
         eval_valid   <= 1'b0;
         line_q       <= '0;
         tall_q       <= 1'b0;
         sprite_count <= '0;
         overflow     <= 1'b0;
         sprite0_hit  <= 1'b0;
      end else begin
         // Read data lags the address by one cycle; the flag and index follow it.
         eval_valid <= (state == SCAN);
         eval_index <= index;

         case (state)
            IDLE: begin
               if (start) begin
                  line_q       <= scanline;
                  tall_q       <= tall_sprites;
                  sprite_count <= '0;
                  overflow     <= 1'b0;
                  sprite0_hit  <= 1'b0;
                  index        <= '0;
                  state        <= SCAN;
               end
            end
            SCAN: begin
               index <= index + 1'b1;
               if (index == IDX_W'(OAM_ENTRIES - 1)) state <= DRAIN;
            end
            DRAIN:   state <= DONE;
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase

         if (write_en) begin
            sprite_count <= sprite_count + 1'b1;
            if (eval_index == '0) sprite0_hit <= 1'b1;
         end
         if (overflow_hit) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sprite_evaluator.sv
// Self-checking bench: OAM memory model, spec-level reference, scenario tasks.
module tb_sprite_evaluator;

   localparam int MAXS = 8;
   localparam int N    = 64;
   localparam int DONE_CYCLE = N + 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  scanline = 8'd0;
   logic        tall = 1'b0;
   logic [5:0]  oam_read_addr;
   logic [31:0] oam_read_data;
   logic [2:0]  sec_write_addr;
   logic [31:0] sec_write_data;
   logic        sec_write_enable;
   logic        busy;
   logic        done;
   logic [3:0]  sprite_count;
   logic        overflow;
   logic        sprite0_hit;

   sprite_evaluator #(.MAX_SPRITES(MAXS), .OAM_ENTRIES(N)) dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .scanline         (scanline),
      .tall_sprites     (tall),
      .oam_read_addr    (oam_read_addr),
      .oam_read_data    (oam_read_data),
      .sec_write_addr   (sec_write_addr),
      .sec_write_data   (sec_write_data),
      .sec_write_enable (sec_write_enable),
      .busy             (busy),
      .done             (done),
      .sprite_count     (sprite_count),
      .overflow         (overflow),
      .sprite0_hit      (sprite0_hit)
   );

   always #5 clk = ~clk;

   // OAM with one-cycle registered read
   logic [31:0] oam [N];
   always @(posedge clk) oam_read_data <= oam[oam_read_addr];

   int pass_cnt = 0;
   int total    = 0;

   logic [31:0] got_data[$];
   int          got_slot[$];
   int          done_cyc;
   int          addr_err;
   int          busy_err;
   int          exp_idx[$];

   task automatic fill(input logic [7:0] y);
      logic [31:0] r;
      for (int i = 0; i < N; i++) begin
         r = $urandom();
         oam[i] = {r[31:8], y};
      end
   endtask

   task automatic set_y(input int i, input logic [7:0] y);
      oam[i][7:0] = y;
   endtask

   // Reference: every entry covering the line, in OAM order.
   task automatic model(input logic [7:0] sl, input logic t);
      int y;
      int h;
      exp_idx.delete();
      h = t ? 16 : 8;
      for (int i = 0; i < N; i++) begin
         y = int'(oam[i][7:0]);
         if (int'(sl) >= y && int'(sl) - y < h) exp_idx.push_back(i);
      end
   endtask

   task automatic run_scan(input logic [7:0] sl, input logic t, input int restart_at);
      got_data.delete();
      got_slot.delete();
      done_cyc = -1;
      addr_err = 0;
      busy_err = 0;
      model(sl, t);
      @(negedge clk);
      scanline = sl;
      tall     = t;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      scanline = 8'($urandom());
      tall     = ~t;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         start = (k == restart_at);
         if (k <= N && oam_read_addr !== 6'(k - 1)) addr_err++;
         if (k > N && oam_read_addr !== 6'd0) addr_err++;
         if (busy !== 1'b1) busy_err++;
         if (sec_write_enable === 1'b1) begin
            got_slot.push_back(int'(sec_write_addr));
            got_data.push_back(sec_write_data);
         end
         if (done === 1'b1) begin
            done_cyc = k;
            break;
         end
      end
      start = 1'b0;
   endtask

   task automatic compare_run(input string name);
      int n_exp;
      int bad;
      logic [3:0] e_cnt;
      n_exp = (exp_idx.size() > MAXS) ? MAXS : exp_idx.size();
      e_cnt = 4'(n_exp);

      total++;
      if (done_cyc !== DONE_CYCLE)
         $display("FAIL %s done_cycle: got %0d want %0d", name, done_cyc, DONE_CYCLE);
      else pass_cnt++;

      total++;
      if (addr_err !== 0) $display("FAIL %s oam_read_addr: %0d bad cycles, want 0", name, addr_err);
      else pass_cnt++;

      total++;
      if (busy_err !== 0) $display("FAIL %s busy: %0d low cycles during run, want 0", name, busy_err);
      else pass_cnt++;

      bad = (got_data.size() != n_exp) ? 1 : 0;
      for (int i = 0; i < n_exp && i < got_data.size(); i++)
         if (got_slot[i] != i || got_data[i] !== oam[exp_idx[i]]) bad = 1;
      total++;
      if (bad != 0)
         $display("FAIL %s writes: got %0d writes (contents differ=%0d) want %0d", name,
                  got_data.size(), bad, n_exp);
      else pass_cnt++;

      total++;
      if (sprite_count !== e_cnt) $display("FAIL %s sprite_count: got %0d want %0d", name, sprite_count, e_cnt);
      else pass_cnt++;

      total++;
      if (overflow !== (exp_idx.size() > MAXS))
         $display("FAIL %s overflow: got %b want %b", name, overflow, exp_idx.size() > MAXS);
      else pass_cnt++;

      total++;
      if (sprite0_hit !== (exp_idx.size() > 0 && exp_idx[0] == 0))
         $display("FAIL %s sprite0_hit: got %b want %b", name, sprite0_hit,
                  (exp_idx.size() > 0 && exp_idx[0] == 0));
      else pass_cnt++;
   endtask

   task automatic test_reset();
      logic [59:0] outs;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      outs = {oam_read_addr, sec_write_addr, sec_write_data, sec_write_enable, busy, done,
              sprite_count, overflow, sprite0_hit};
      total++;
      if (outs !== '0) $display("FAIL reset_outputs: got %h want 0", outs);
      else pass_cnt++;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_no_hits();
      fill(8'hFF);
      run_scan(8'd100, 1'b0, 0);
      compare_run("no_hits");
   endtask

   task automatic test_three_hits();
      fill(8'hFF);
      set_y(3, 8'd96);
      set_y(10, 8'd96);
      set_y(40, 8'd96);
      run_scan(8'd100, 1'b0, 0);
      compare_run("three_hits");
   endtask

   task automatic test_overflow();
      fill(8'hFF);
      for (int i = 0; i < 10; i++) set_y(i, 8'd50);
      run_scan(8'd57, 1'b0, 0);
      compare_run("overflow_57");
      run_scan(8'd58, 1'b0, 0);
      compare_run("overflow_58");
   endtask

   task automatic test_tall();
      fill(8'hFF);
      set_y(7, 8'd50);
      run_scan(8'd65, 1'b1, 0);
      compare_run("tall_65");
      run_scan(8'd66, 1'b1, 0);
      compare_run("tall_66");
      run_scan(8'd65, 1'b0, 0);
      compare_run("short_65");
      set_y(7, 8'd200);
      run_scan(8'd10, 1'b1, 0);
      compare_run("no_wrap");
   endtask

   task automatic test_hold();
      logic [5:0] snap;
      snap = {sprite_count, overflow, sprite0_hit};
      repeat (6) begin
         @(negedge clk);
         scanline = 8'($urandom());
         tall     = 1'($urandom());
      end
      total++;
      if ({sprite_count, overflow, sprite0_hit} !== snap || busy !== 1'b0)
         $display("FAIL hold: got %h busy=%b want %h busy=0",
                  {sprite_count, overflow, sprite0_hit}, busy, snap);
      else pass_cnt++;
   endtask

   task automatic test_restart_ignored();
      fill(8'hFF);
      for (int i = 20; i < 26; i++) set_y(i, 8'd30);
      run_scan(8'd33, 1'b0, 30);
      compare_run("restart_ignored");
   endtask

   task automatic test_random();
      logic [7:0] sl;
      int y;
      for (int r = 0; r < 5; r++) begin
         sl = 8'($urandom_range(0, 255));
         fill(8'hFF);
         for (int i = 0; i < N; i++) begin
            y = int'(sl) - int'($urandom_range(0, 24)) + 4;
            if ($urandom_range(0, 3) != 0) set_y(i, 8'(y));
         end
         run_scan(sl, 1'($urandom()), 0);
         compare_run($sformatf("random_%0d", r));
      end
   endtask

   task automatic test_back_to_back();
      fill(8'hFF);
      set_y(0, 8'd9);
      set_y(63, 8'd12);
      run_scan(8'd15, 1'b0, 0);
      compare_run("b2b_first");
      run_scan(8'd19, 1'b1, 0);
      compare_run("b2b_second");
   endtask

   task automatic test_reset_abort();
      int wr;
      int err;
      logic [59:0] outs;
      fill(8'hFF);
      set_y(5, 8'd96);
      set_y(12, 8'd96);
      wr = 0;
      @(negedge clk);
      scanline = 8'd100;
      tall     = 1'b0;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int k = 1; k < 20; k++) begin
         @(negedge clk);
         if (sec_write_enable === 1'b1) wr++;
      end
      @(negedge clk);
      total++;
      if (wr !== 2 || sprite_count !== 4'd2)
         $display("FAIL abort_pre: got %0d writes count=%0d want 2 and 2", wr, sprite_count);
      else pass_cnt++;
      reset = 1'b1;
      #1;
      outs = {oam_read_addr, sec_write_addr, sec_write_data, sec_write_enable, busy, done,
              sprite_count, overflow, sprite0_hit};
      total++;
      if (outs !== '0) $display("FAIL abort_outputs: got %h want 0", outs);
      else pass_cnt++;
      @(negedge clk);
      reset = 1'b0;
      err = 0;
      repeat (80) begin
         @(negedge clk);
         if (sec_write_enable !== 1'b0 || done !== 1'b0 || busy !== 1'b0) err++;
      end
      total++;
      if (err !== 0) $display("FAIL abort_quiet: got %0d active cycles want 0", err);
      else pass_cnt++;
      run_scan(8'd100, 1'b0, 0);
      compare_run("abort_fresh");
   endtask

   initial begin
      for (int i = 0; i < N; i++) oam[i] = 32'hFFFF_FFFF;
      test_reset();
      test_no_hits();
      test_three_hits();
      test_hold();
      test_overflow();
      test_hold();
      test_tall();
      test_restart_ignored();
      test_random();
      test_back_to_back();
      test_reset_abort();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
